// File: rtl/bpu_sram_pkg.sv
// Shared widths and types for the BPU table SRAM requester.
// Lane i of an entry covers data bits [i*LANE_W +: LANE_W].
package bpu_sram_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned LANES  = 2;
    localparam int unsigned LANE_W = DATA_W / LANES;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic [LANES-1:0]  mask;
    } wr_entry_t;

endpackage

// File: rtl/sram_wbuf.sv
// Small circular write buffer. Exposes the occupancy, the head entry, and
// per-slot index/valid so the owner can detect read-after-write hazards.
module sram_wbuf
    import bpu_sram_pkg::*;
#(
    parameter int unsigned WBUF_DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  wr_entry_t                          push_entry,
    input  logic                               pop,
    output logic [CNT_W-1:0]                   count,
    output wr_entry_t                          head,
    output logic [WBUF_DEPTH-1:0]              ent_valid,
    output logic [WBUF_DEPTH-1:0][ADDR_W-1:0]  ent_idx
);

    localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

    wr_entry_t               mem_q [WBUF_DEPTH];
    wr_entry_t               mem_d [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: slot validity gates every use.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        count     = count_q;
        head      = mem_q[rd_ptr_q];
        ent_valid = valid_q;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            ent_idx[i] = mem_q[i].idx;
        end
    end

endmodule

// File: rtl/sram_1p_req_ctrl.sv
// Serialises independent read and masked-write streams onto one RW0 SRAM port,
// zeroing the array after reset and stalling reads that hit buffered writes.
module sram_1p_req_ctrl
    import bpu_sram_pkg::*;
#(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned WBUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_idx,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_idx,
    input  logic [DATA_W-1:0] w_req_data,
    input  logic [LANES-1:0]  w_req_mask,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LANES-1:0]  sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned       CNT_W      = $clog2(WBUF_DEPTH + 1);
    localparam logic [CNT_W-1:0]  WB_FULL    = CNT_W'(WBUF_DEPTH);
    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   hold_q, hold_d;

    logic                              wb_push, wb_pop;
    wr_entry_t                         wb_push_entry, wb_head;
    logic [CNT_W-1:0]                  wb_count;
    logic [WBUF_DEPTH-1:0]             wb_ent_valid;
    logic [WBUF_DEPTH-1:0][ADDR_W-1:0] wb_ent_idx;
    logic                              wb_full, hazard;

    sram_wbuf #(.WBUF_DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk        (clock),
        .rst        (reset),
        .push       (wb_push),
        .push_entry (wb_push_entry),
        .pop        (wb_pop),
        .count      (wb_count),
        .head       (wb_head),
        .ent_valid  (wb_ent_valid),
        .ent_idx    (wb_ent_idx)
    );

    assign wb_full       = (wb_count == WB_FULL);
    assign wb_push       = w_req_valid && w_req_ready;
    assign wb_push_entry = '{idx: w_req_idx, data: w_req_data, mask: w_req_mask};

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            if (wb_ent_valid[i] && (wb_ent_idx[i] == r_req_idx)) hazard = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        resp_valid_d = 1'b0;
        hold_d       = resp_valid_q ? sram_rdata : hold_q;
        r_req_ready  = 1'b0;
        w_req_ready  = 1'b0;
        wb_pop       = 1'b0;
        sram_en      = 1'b0;
        sram_wmode   = 1'b0;
        sram_addr    = '0;
        sram_wmask   = '0;
        sram_wdata   = '0;
        if (!reset) begin
            case (state_q)
                INIT: begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = sweep_q;
                    sram_wmask = '1;
                    sweep_d    = sweep_q + ADDR_W'(1);
                    if (sweep_q == SWEEP_LAST) begin
                        state_d = RUN;
                        sweep_d = '0;
                    end
                end
                RUN: begin
                    w_req_ready = !wb_full;
                    r_req_ready = !hazard && !wb_full;
                    // A full buffer always wins the port so writers never starve.
                    if (wb_full) begin
                        wb_pop = 1'b1;
                    end else if (r_req_valid && !hazard) begin
                        sram_en      = 1'b1;
                        sram_addr    = r_req_idx;
                        resp_valid_d = 1'b1;
                    end else if (wb_count != '0) begin
                        wb_pop = 1'b1;
                    end
                    if (wb_pop) begin
                        sram_en    = 1'b1;
                        sram_wmode = 1'b1;
                        sram_addr  = wb_head.idx;
                        sram_wmask = wb_head.mask;
                        sram_wdata = wb_head.data;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= INIT;
            sweep_q      <= '0;
            resp_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            resp_valid_q <= resp_valid_d;
            hold_q       <= hold_d;
        end
    end

    // Response is suppressed during reset so an in-flight read is dropped.
    assign r_resp_valid = resp_valid_q && !reset;
    assign r_resp_data  = reset ? '0 : (resp_valid_q ? sram_rdata : hold_q);

endmodule

// File: tb/tb_sram_1p_req_ctrl.sv
// Scoreboard bench for sram_1p_req_ctrl: an array-plus-queues reference model
// predicts port usage and read data; a monitor checks responses as they appear.
module tb_sram_1p_req_ctrl;

    localparam int AW = 9;
    localparam int DW = 24;
    localparam int ND = 512;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          r_req_valid = 1'b0;
    logic          r_req_ready;
    logic [AW-1:0] r_req_idx = '0;
    logic          r_resp_valid;
    logic [DW-1:0] r_resp_data;
    logic          w_req_valid = 1'b0;
    logic          w_req_ready;
    logic [AW-1:0] w_req_idx = '0;
    logic [DW-1:0] w_req_data = '0;
    logic [1:0]    w_req_mask = '0;
    logic          sram_en;
    logic          sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [1:0]    sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    sram_1p_req_ctrl #(.DEPTH(ND), .WBUF_DEPTH(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .r_req_valid  (r_req_valid),
        .r_req_ready  (r_req_ready),
        .r_req_idx    (r_req_idx),
        .r_resp_valid (r_resp_valid),
        .r_resp_data  (r_resp_data),
        .w_req_valid  (w_req_valid),
        .w_req_ready  (w_req_ready),
        .w_req_idx    (w_req_idx),
        .w_req_data   (w_req_data),
        .w_req_mask   (w_req_mask),
        .sram_en      (sram_en),
        .sram_wmode   (sram_wmode),
        .sram_addr    (sram_addr),
        .sram_wmask   (sram_wmask),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural SRAM macro: 1-cycle read latency, per-lane write enables.
    logic [DW-1:0] sram_mem [ND];
    initial for (int i = 0; i < ND; i++) sram_mem[i] = DW'($urandom);
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode)
                sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~{{12{sram_wmask[1]}}, {12{sram_wmask[0]}}})
                                     | (sram_wdata & {{12{sram_wmask[1]}}, {12{sram_wmask[0]}}});
            else
                sram_rdata <= sram_mem[sram_addr];
        end
    end

    always @(posedge clock) cyc++;

    // Reference model: array view of contents in write-acceptance order,
    // plus the list of accepted-but-not-yet-issued writes.
    typedef struct { logic [AW-1:0] idx; logic [DW-1:0] data; logic [1:0] mask; } wr_t;
    typedef struct { logic [DW-1:0] data; int acc; } rd_t;
    logic [DW-1:0] ref_mem [ND];
    wr_t wq[$];
    rd_t rq[$];
    bit  run_mode = 1'b0;
    int  sweep_idx = 0;
    logic [DW-1:0] last_resp = '0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [1:0] m);
        logic [DW-1:0] r;
        r = old_v;
        if (m[0]) r[11:0]  = new_v[11:0];
        if (m[1]) r[23:12] = new_v[23:12];
        return r;
    endfunction

    always @(negedge clock) begin : observer
        int cnt;
        bit haz, r_acc, w_acc, issue_w;
        logic [36:0] act_p, exp_p;
        wr_t ent;
        rd_t rd;
        if (reset) begin
            chk("reset_outputs", {r_req_ready, w_req_ready, r_resp_valid, r_resp_data}, '0);
            run_mode  = 1'b0;
            sweep_idx = 0;
            wq.delete();
            rq.delete();
            for (int i = 0; i < ND; i++) ref_mem[i] = '0;
        end else if (!run_mode) begin
            chk("sweep_port", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata},
                {1'b1, 1'b1, sweep_idx[8:0], 2'b11, 24'h0});
            chk("sweep_ready", {r_req_ready, w_req_ready}, '0);
            sweep_idx++;
            if (sweep_idx == ND) run_mode = 1'b1;
        end else begin
            cnt = wq.size();
            haz = 1'b0;
            foreach (wq[i]) if (wq[i].idx == r_req_idx) haz = 1'b1;
            chk("w_ready", w_req_ready, cnt < 2);
            chk("r_ready", r_req_ready, !haz && cnt < 2);
            r_acc   = r_req_valid && r_req_ready;
            w_acc   = w_req_valid && w_req_ready;
            issue_w = (cnt == 2) || (!r_acc && cnt > 0);
            if (issue_w) begin
                act_p = {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata};
                exp_p = {1'b1, 1'b1, wq[0].idx, wq[0].mask, wq[0].data};
            end else if (r_acc) begin
                act_p = {sram_en, sram_wmode, sram_addr, 26'h0};
                exp_p = {1'b1, 1'b0, r_req_idx, 26'h0};
            end else begin
                act_p = {sram_en, 36'h0};
                exp_p = '0;
            end
            chk("port_arb", act_p, exp_p);
            if (issue_w) void'(wq.pop_front());
            if (r_acc) begin
                rd.data = ref_mem[r_req_idx];
                rd.acc  = cyc;
                rq.push_back(rd);
            end
            if (w_acc) begin
                ref_mem[w_req_idx] = merge(ref_mem[w_req_idx], w_req_data, w_req_mask);
                ent.idx  = w_req_idx;
                ent.data = w_req_data;
                ent.mask = w_req_mask;
                wq.push_back(ent);
            end
        end
    end

    always @(negedge clock) begin : monitor
        rd_t e;
        if (reset) begin
            last_resp = '0;
        end else if (r_resp_valid) begin
            chk("resp_pending", rq.size() > 0, 1'b1);
            if (rq.size() > 0) begin
                e = rq.pop_front();
                chk("resp_data", r_resp_data, e.data);
                chk("resp_latency", cyc, e.acc + 1);
                last_resp = e.data;
            end
        end else begin
            chk("resp_hold", r_resp_data, last_resp);
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_run();
        int t = 0;
        while (!run_mode && t < 2000) begin step(1); t++; end
        chk("sweep_done", run_mode, 1'b1);
    endtask

    task automatic do_read(input logic [AW-1:0] idx, output int waited);
        bit ok = 1'b0;
        waited = 0;
        r_req_valid = 1'b1;
        r_req_idx   = idx;
        while (!ok && waited < 50) begin
            @(negedge clock);
            ok = r_req_ready;
            @(posedge clock); #1;
            waited++;
        end
        r_req_valid = 1'b0;
        chk("read_accept", ok, 1'b1);
    endtask

    task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] d, input logic [1:0] m);
        bit ok = 1'b0;
        int t = 0;
        w_req_valid = 1'b1;
        w_req_idx   = idx;
        w_req_data  = d;
        w_req_mask  = m;
        while (!ok && t < 50) begin
            @(negedge clock);
            ok = w_req_ready;
            @(posedge clock); #1;
            t++;
        end
        w_req_valid = 1'b0;
        chk("write_accept", ok, 1'b1);
    endtask

    task automatic do_rw(input logic [AW-1:0] ridx, input logic [AW-1:0] widx,
                         input logic [DW-1:0] d, input logic [1:0] m);
        bit racc = 1'b0, wacc = 1'b0;
        int t = 0;
        r_req_valid = 1'b1; r_req_idx = ridx;
        w_req_valid = 1'b1; w_req_idx = widx; w_req_data = d; w_req_mask = m;
        while (!(racc && wacc) && t < 50) begin
            @(negedge clock);
            if (r_req_valid && r_req_ready) racc = 1'b1;
            if (w_req_valid && w_req_ready) wacc = 1'b1;
            @(posedge clock); #1;
            if (racc) r_req_valid = 1'b0;
            if (wacc) w_req_valid = 1'b0;
            t++;
        end
        chk("rw_accept", {racc, wacc}, 2'b11);
        chk("rw_same_cycle", t, 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        int w;
        step(3);
        reset = 1'b0;
        wait_run();

        do_read(9'd300, w);
        step(3);
        chk("rd300_zero", r_resp_data, 24'h000000);

        do_write(9'd5, 24'hABC123, 2'b11);
        do_read(9'd5, w);
        chk("rd5_stall_cycles", w, 2);
        step(4);
        chk("rd5_held", r_resp_data, 24'hABC123);

        do_write(9'd7, 24'hFFFFFF, 2'b11);
        do_write(9'd7, 24'h000111, 2'b01);
        do_write(9'd7, 24'h555555, 2'b00);
        do_read(9'd7, w);
        step(3);
        chk("rd7_masked", r_resp_data, 24'hFFF111);

        do_rw(9'd9, 9'd9, 24'h123456, 2'b11);
        step(2);
        chk("rd9_prewrite", r_resp_data, 24'h000000);
        do_read(9'd9, w);
        step(3);
        chk("rd9_postwrite", r_resp_data, 24'h123456);

        // Continuous reads of idx 1 while writes to idx 2 fill the buffer.
        r_req_valid = 1'b1; r_req_idx = 9'd1;
        w_req_valid = 1'b1; w_req_idx = 9'd2; w_req_mask = 2'b11;
        for (int i = 0; i < 12; i++) begin
            w_req_data = DW'($urandom);
            step(1);
        end
        r_req_valid = 1'b0; w_req_valid = 1'b0;
        step(5);

        // Reset in RUN with a read in flight and writes buffered.
        r_req_valid = 1'b1; r_req_idx = 9'd21;
        w_req_valid = 1'b1; w_req_idx = 9'd20; w_req_data = 24'hDEAD01; w_req_mask = 2'b11;
        step(2);
        reset = 1'b1; r_req_valid = 1'b0; w_req_valid = 1'b0;
        step(1);
        reset = 1'b0;
        step(100);
        // Reset again at sweep counter 100.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        wait_run();
        do_read(9'd20, w);
        step(3);
        chk("rd20_after_reset", r_resp_data, 24'h000000);

        for (int i = 0; i < 1500; i++) begin
            r_req_valid = 1'($urandom);
            r_req_idx   = AW'($urandom_range(0, 7));
            w_req_valid = 1'($urandom);
            w_req_idx   = AW'($urandom_range(0, 7));
            w_req_data  = DW'($urandom);
            w_req_mask  = 2'($urandom);
            step(1);
        end
        r_req_valid = 1'b0; w_req_valid = 1'b0;
        step(10);
        chk("writes_drained", wq.size(), 0);
        chk("reads_answered", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
